// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants bounded bursts; FIFO full stalls, almost_full only blocks new grants.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wrreq,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] TOP       = OW'(NUM_REQ - 1);
  localparam logic [OW:0]   NREQ_W    = (OW + 1)'(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nx;
  logic [OW-1:0]       rr_ptr, rr_nx;
  logic [OW-1:0]       owner_nx, sel;
  logic [BW-1:0]       beats, beats_nx;
  logic                found;
  logic                own_valid, own_last;
  logic                xfer, burst_end;
  logic [2*NUM_REQ-1:0] rot;
  logic [OW:0]         sum;

  assign busy = (state == BURST);

  // owner's view of the request bundle
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    rot   = {req_valid, req_valid} >> rr_ptr;
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (OW + 1)'(k);
        if (sum >= NREQ_W)
          sum = sum - NREQ_W;
        sel = sum[OW-1:0];
      end
    end
  end

  assign xfer      = busy & own_valid & ~fifo_full;
  assign burst_end = ~own_valid |
                     (xfer & (own_last | (beats == LAST_BEAT)));

  always_ff @(posedge clk) begin
    if (sclr) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beats  <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_nx;
      beats  <= beats_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr_ptr;
    beats_nx = beats;
    unique case (state)
      IDLE: begin
        if (found && !fifo_full && !fifo_almost_full) begin
          state_nx = BURST;
          owner_nx = sel;
          rr_nx    = (sel == TOP) ? '0 : sel + 1'b1;
          beats_nx = '0;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_nx = IDLE;
          beats_nx = '0;
        end else if (xfer) begin
          beats_nx = beats + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = busy & (owner == OW'(i)) & ~fifo_full;
    fifo_wrreq = xfer;
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a 4-requester instance
// plus a 3-requester instance for wrap-around release.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        sclr;
  logic [3:0]  v, l, rdy;
  logic [31:0] d;
  logic        full, af, wr, busy;
  logic [7:0]  fd;
  logic [1:0]  own;

  logic [2:0]  v3, l3, rdy3;
  logic [23:0] d3;
  logic        full3, af3, wr3, busy3;
  logic [7:0]  fd3;
  logic [1:0]  own3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8)) dut (
    .clk(clk), .sclr(sclr),
    .req_valid(v), .req_data(d), .req_last(l), .req_ready(rdy),
    .fifo_full(full), .fifo_almost_full(af),
    .fifo_wrreq(wr), .fifo_data(fd), .owner(own), .busy(busy)
  );

  fifo_write_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(8)) u3 (
    .clk(clk), .sclr(sclr),
    .req_valid(v3), .req_data(d3), .req_last(l3), .req_ready(rdy3),
    .fifo_full(full3), .fifo_almost_full(af3),
    .fifo_wrreq(wr3), .fifo_data(fd3), .owner(own3), .busy(busy3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    v = '0; l = '0; v3 = '0; l3 = '0;
    full = 1'b0; af = 1'b0;
    step();
    sclr = 1'b0;
  endtask

  task automatic test_reset();
    v = 4'hF; l = '0; sclr = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (rdy !== 4'b0 || wr !== 1'b0 || busy !== 1'b0 || own !== 2'd0) begin
        failures++;
        $display("FAIL reset c%0d: rdy=%b wr=%b busy=%b owner=%0d want 0000 0 0 0",
                 c, rdy, wr, busy, own);
      end
    end
    sclr = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || own !== 2'd0 || rdy !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant: busy=%b owner=%0d rdy=%b want 1 0 0001",
               busy, own, rdy);
    end
  endtask

  task automatic test_round_robin();
    logic       expw;
    logic [1:0] expo;
    do_reset();
    v = 4'hF;
    #1;
    checks++;
    if (wr !== 1'b0) begin
      failures++;
      $display("FAIL rr_c0: wr=%b want 0", wr);
    end
    for (int c = 1; c <= 44; c++) begin
      step();
      expw = (c % 9) != 0;
      expo = 2'((c / 9) % 4);
      checks++;
      if (wr !== expw) begin
        failures++;
        $display("FAIL rr_wr c%0d: wr=%b want %b", c, wr, expw);
      end else if (expw && (own !== expo || fd !== 8'hA0 + 8'(expo) ||
                            rdy !== 4'(1 << expo))) begin
        failures++;
        $display("FAIL rr_owner c%0d: owner=%0d data=%h rdy=%b want %0d %h %b",
                 c, own, fd, rdy, expo, 8'hA0 + 8'(expo), 4'(1 << expo));
      end
    end
    v = '0;
  endtask

  task automatic test_packet_end();
    int nw;
    do_reset();
    nw = 0;
    d[23:16] = 8'h21;
    v = 4'b0100;
    #1;
    for (int w = 0; w < 3; w++) begin
      step();
      d[23:16] = 8'h21 + 8'(w);
      l[2] = (w == 2);
      #1;
      if (wr === 1'b1) nw++;
      checks++;
      if (wr !== 1'b1 || fd !== 8'h21 + 8'(w) || own !== 2'd2) begin
        failures++;
        $display("FAIL pkt2_beat%0d: wr=%b data=%h owner=%0d want 1 %h 2",
                 w, wr, fd, own, 8'h21 + 8'(w));
      end
    end
    step();
    v = '0; l = '0;
    #1;
    if (wr === 1'b1) nw++;
    checks++;
    if (busy !== 1'b0 || nw != 3) begin
      failures++;
      $display("FAIL pkt2_end: busy=%b writes=%0d want 0 3", busy, nw);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin
      failures++;
      $display("FAIL pkt2_rr: rr_ptr=%0d want 3", dut.rr_ptr);
    end
    nw = 0;
    d[31:24] = 8'h31;
    v = 4'b1000; l = 4'b1000;
    #1;
    step();
    if (wr === 1'b1) nw++;
    checks++;
    if (wr !== 1'b1 || fd !== 8'h31 || own !== 2'd3) begin
      failures++;
      $display("FAIL pkt3_beat: wr=%b data=%h owner=%0d want 1 31 3", wr, fd, own);
    end
    step();
    v = '0; l = '0;
    #1;
    if (wr === 1'b1) nw++;
    step();
    if (wr === 1'b1) nw++;
    checks++;
    if (busy !== 1'b0 || nw != 1) begin
      failures++;
      $display("FAIL pkt3_end: busy=%b writes=%0d want 0 1", busy, nw);
    end
    d = 32'hA3A2A1A0;
  endtask

  task automatic test_back_pressure();
    int   nw;
    logic expw, expb;
    do_reset();
    nw = 0;
    v = 4'b0001;
    #1;
    for (int c = 1; c <= 13; c++) begin
      step();
      full = (c >= 4 && c <= 7);
      #1;
      expw = (c <= 3) || (c >= 8 && c <= 12);
      expb = (c <= 12);
      if (wr === 1'b1) nw++;
      checks++;
      if (wr !== expw || busy !== expb || rdy !== {3'b0, expw}) begin
        failures++;
        $display("FAIL bp c%0d: wr=%b busy=%b rdy=%b want %b %b %b",
                 c, wr, busy, rdy, expw, expb, {3'b0, expw});
      end
    end
    checks++;
    if (nw != 8) begin
      failures++;
      $display("FAIL bp_total: writes=%0d want 8", nw);
    end
    v = '0; full = 1'b0;
  endtask

  task automatic test_almost_full();
    logic expb;
    do_reset();
    af = 1'b1;
    v = 4'b0010;
    #1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || wr !== 1'b0) begin
        failures++;
        $display("FAIL af_hold c%0d: busy=%b wr=%b want 0 0", c, busy, wr);
      end
    end
    af = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      af = (c >= 3 && c <= 11);
      #1;
      expb = (c >= 1 && c <= 8) || (c == 13);
      checks++;
      if (busy !== expb || wr !== expb || (expb && own !== 2'd1)) begin
        failures++;
        $display("FAIL af c%0d: busy=%b wr=%b owner=%0d want %b %b 1",
                 c, busy, wr, own, expb, expb);
      end
    end
    v = '0; af = 1'b0;
  endtask

  task automatic test_release_wrap();
    do_reset();
    d3 = {8'hC2, 8'hC1, 8'hC0};
    v3 = 3'b100;
    #1;
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if (wr3 !== 1'b1 || own3 !== 2'd2 || fd3 !== 8'hC2) begin
        failures++;
        $display("FAIL rel_beat%0d: wr=%b owner=%0d data=%h want 1 2 c2",
                 c, wr3, own3, fd3);
      end
    end
    step();
    v3 = 3'b011;
    #1;
    checks++;
    if (wr3 !== 1'b0 || busy3 !== 1'b1) begin
      failures++;
      $display("FAIL rel_drop: wr=%b busy=%b want 0 1", wr3, busy3);
    end
    step();
    checks++;
    if (busy3 !== 1'b0 || u3.rr_ptr !== 2'd0) begin
      failures++;
      $display("FAIL rel_idle: busy=%b rr_ptr=%0d want 0 0", busy3, u3.rr_ptr);
    end
    step();
    checks++;
    if (busy3 !== 1'b1 || own3 !== 2'd0 || wr3 !== 1'b1 || fd3 !== 8'hC0) begin
      failures++;
      $display("FAIL rel_wrap: busy=%b owner=%0d wr=%b data=%h want 1 0 1 c0",
               busy3, own3, wr3, fd3);
    end
    v3 = '0;
  endtask

  initial begin
    sclr = 1'b1;
    v = '0; l = '0; d = 32'hA3A2A1A0;
    full = 1'b0; af = 1'b0;
    v3 = '0; l3 = '0; d3 = '0;
    full3 = 1'b0; af3 = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_end();
    test_back_pressure();
    test_almost_full();
    test_release_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
